// File: rtl/quad_up_down_decoder.sv
// Quadrature up/down decoder.
// Synchronizes asynchronous A/B phase inputs, decodes each Gray-code step
// (00->01->11->10->00 is up, the reverse is down) and keeps a modulo-MODULO
// position count. The count can be loaded synchronously. Step and wrap are
// one-cycle strobes. Err is sticky and records any double-bit phase jump.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   qa_i/qb_i  phase A/B, asynchronous to clk_i
//   load_i     load din_i into the count; din_i >= MODULO clamps to MODULO-1
//   din_i      load value
//   clr_err_i  clears the sticky error; a same-cycle illegal jump wins
//   dout_o     position count, 0..MODULO-1
//   dir_o      direction of the last valid step (1 = up)
//   step_o     one-cycle pulse per counted step
//   wrap_o     one-cycle pulse when a step wraps the count
//   err_o      sticky illegal-transition flag
module quad_up_down_decoder #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MODULO      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             qa_i,
  input  logic             qb_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dir_o,
  output logic             step_o,
  output logic             wrap_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULO - 1);
  localparam int unsigned      InitCntW = $clog2(SYNC_STAGES + 1);
  localparam logic [InitCntW-1:0] InitLast = InitCntW'(SYNC_STAGES);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                 state_q, state_d;
  logic [InitCntW-1:0]    init_cnt_q, init_cnt_d;
  logic [SYNC_STAGES-1:0] qa_sync_q, qb_sync_q;
  logic [1:0]             prev_q;
  logic [1:0]             cur;
  logic [WIDTH-1:0]       dout_q, dout_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   wrap_q, wrap_d;
  logic                   err_q, err_d;
  logic                   step_up, step_dn, illegal;

  assign cur = {qa_sync_q[SYNC_STAGES-1], qb_sync_q[SYNC_STAGES-1]};

  // Init holds off decoding until the synchronizer has flushed the zeros it
  // was reset to, so a phase level held across reset release becomes the
  // baseline instead of looking like a transition.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + InitCntW'(1);
        if (init_cnt_q == InitLast) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    illegal = 1'b0;
    if (state_q == StRun) begin
      case ({prev_q, cur})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up = 1'b1;
        4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_dn = 1'b1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    dout_d = dout_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (clr_err_i) err_d = 1'b0;
    if (illegal)   err_d = 1'b1;
    // Load beats a same-cycle step; prev_q still tracks so it is not replayed.
    if (load_i) begin
      dout_d = (din_i > MaxCount) ? MaxCount : din_i;
    end else if (step_up) begin
      dir_d  = 1'b1;
      step_d = 1'b1;
      if (dout_q == MaxCount) begin
        dout_d = '0;
        wrap_d = 1'b1;
      end else begin
        dout_d = dout_q + WIDTH'(1);
      end
    end else if (step_dn) begin
      dir_d  = 1'b0;
      step_d = 1'b1;
      if (dout_q == '0) begin
        dout_d = MaxCount;
        wrap_d = 1'b1;
      end else begin
        dout_d = dout_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      qa_sync_q  <= '0;
      qb_sync_q  <= '0;
      prev_q     <= 2'b00;
      dout_q     <= '0;
      dir_q      <= 1'b1;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      qa_sync_q  <= {qa_sync_q[SYNC_STAGES-2:0], qa_i};
      qb_sync_q  <= {qb_sync_q[SYNC_STAGES-2:0], qb_i};
      prev_q     <= cur;
      dout_q     <= dout_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign dout_o = dout_q;
  assign dir_o  = dir_q;
  assign step_o = step_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;

endmodule
